// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS control unit: state FSM plus IR-field strobe decode
module multicycle_control #(
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] state,
    output logic       halted,
    output logic       PCWre,
    output logic       IRWre,
    output logic       RegWre,
    output logic [1:0] RegDst,
    output logic       WrRegDSrc,
    output logic       DBDataSrc,
    output logic       ALUSrcB,
    output logic       ExtSel,
    output logic [2:0] ALUOp,
    output logic       mRD,
    output logic       mWR,
    output logic [1:0] PCSrc
);

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } stateT;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    stateT curState;
    stateT idNext;

    logic isRType, isRAlu, isJr, isAddi, isOri, isLw, isSw, isBeq, isJ, isJal, isHalt;
    logic isNop;

    always_comb begin
        isRType = (opcode == OP_RTYPE);
        isJr    = isRType && (funct == FN_JR);
        isRAlu  = isRType && ((funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                              (funct == FN_OR)  || (funct == FN_SLT));
        isAddi  = (opcode == OP_ADDI);
        isOri   = (opcode == OP_ORI);
        isLw    = (opcode == OP_LW);
        isSw    = (opcode == OP_SW);
        isBeq   = (opcode == OP_BEQ);
        isJ     = (opcode == OP_J);
        isJal   = (opcode == OP_JAL);
        isHalt  = (opcode == HALT_OP);
        // Anything not recognised, including R-type with an unknown funct, retires in ID as a NOP
        isNop   = !(isRAlu || isJr || isAddi || isOri || isLw || isSw ||
                    isBeq || isJ || isJal || isHalt);
    end

    always_comb begin
        if (isJ || isJal || isJr || isHalt || isNop)
            idNext = S_IF;
        else if (isLw || isSw)
            idNext = S_EXE_LS;
        else if (isBeq)
            idNext = S_EXE_BR;
        else
            idNext = S_EXE_AL;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            curState <= S_IF;
            halted   <= 1'b0;
        end else if (halted) begin
            curState <= S_IF;
        end else begin
            case (curState)
                S_IF:     curState <= S_ID;
                S_ID: begin
                    if (isHalt)
                        halted <= 1'b1;
                    curState <= idNext;
                end
                S_EXE_LS: curState <= S_MEM;
                S_MEM:    curState <= isLw ? S_WB_LD : S_IF;
                S_EXE_AL: curState <= S_WB_AL;
                default:  curState <= S_IF;
            endcase
        end
    end

    assign state = curState;

    // Selectors follow the latched opcode for the whole instruction; write strobes are state-gated
    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        RegWre    = 1'b0;
        RegDst    = 2'b01;
        WrRegDSrc = 1'b1;
        DBDataSrc = 1'b0;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b1;
        ALUOp     = ALU_ADD;
        mRD       = 1'b0;
        mWR       = 1'b0;
        PCSrc     = 2'b00;

        if (isJal)
            RegDst = 2'b00;
        else if (isRType)
            RegDst = 2'b10;

        WrRegDSrc = !isJal;
        DBDataSrc = isLw;
        ALUSrcB   = isAddi || isOri || isLw || isSw;
        ExtSel    = !isOri;

        if (isBeq)
            ALUOp = ALU_SUB;
        else if (isOri)
            ALUOp = ALU_OR;
        else if (isRType) begin
            case (funct)
                FN_SUB:  ALUOp = ALU_SUB;
                FN_AND:  ALUOp = ALU_AND;
                FN_OR:   ALUOp = ALU_OR;
                FN_SLT:  ALUOp = ALU_SLT;
                default: ALUOp = ALU_ADD;
            endcase
        end

        if (isJ || isJal)
            PCSrc = 2'b11;
        else if (isJr)
            PCSrc = 2'b10;
        else if (curState == S_EXE_BR && zero)
            PCSrc = 2'b01;

        if (!halted) begin
            case (curState)
                S_IF: IRWre = 1'b1;
                S_ID: begin
                    PCWre  = isJ || isJal || isJr || isNop;
                    RegWre = isJal;
                end
                S_EXE_BR: PCWre = 1'b1;
                S_MEM: begin
                    mRD   = isLw;
                    mWR   = isSw;
                    PCWre = isSw;
                end
                S_WB_LD: begin
                    PCWre  = 1'b1;
                    RegWre = 1'b1;
                end
                S_WB_AL: begin
                    PCWre  = 1'b1;
                    RegWre = 1'b1;
                end
                default: ;
            endcase
        end

        // Reset aborts the instruction: nothing may drive the datapath while it is held
        if (!RST) begin
            PCWre     = 1'b0;
            IRWre     = 1'b0;
            RegWre    = 1'b0;
            RegDst    = 2'b00;
            WrRegDSrc = 1'b0;
            DBDataSrc = 1'b0;
            ALUSrcB   = 1'b0;
            ExtSel    = 1'b0;
            ALUOp     = ALU_ADD;
            mRD       = 1'b0;
            mWR       = 1'b0;
            PCSrc     = 2'b00;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

    logic       CLK;
    logic       RST;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] state;
    logic       halted;
    logic       PCWre;
    logic       IRWre;
    logic       RegWre;
    logic [1:0] RegDst;
    logic       WrRegDSrc;
    logic       DBDataSrc;
    logic       ALUSrcB;
    logic       ExtSel;
    logic [2:0] ALUOp;
    logic       mRD;
    logic       mWR;
    logic [1:0] PCSrc;

    int checks = 0;
    int errors = 0;

    multicycle_control dut (
        .CLK(CLK), .RST(RST), .opcode(opcode), .funct(funct), .zero(zero),
        .state(state), .halted(halted), .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre),
        .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc), .ALUSrcB(ALUSrcB),
        .ExtSel(ExtSel), .ALUOp(ALUOp), .mRD(mRD), .mWR(mWR), .PCSrc(PCSrc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        RST = 1'b0; opcode = 6'b0; funct = 6'b100000; zero = 1'b0;
        #12;
        chk("rst_state", {29'b0, state}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_irwre", {31'b0, IRWre}, 32'd0);
        @(negedge CLK); RST = 1'b1;
        #1;

        // add: 000,001,110,111,000
        chk("add_if_state", {29'b0, state}, 32'd0);
        chk("add_if_irwre", {31'b0, IRWre}, 32'd1);
        tick();
        chk("add_id_state", {29'b0, state}, 32'd1);
        chk("add_id_regwre", {31'b0, RegWre}, 32'd0);
        chk("add_id_pcwre", {31'b0, PCWre}, 32'd0);
        tick();
        chk("add_exe_state", {29'b0, state}, 32'd6);
        chk("add_exe_regwre", {31'b0, RegWre}, 32'd0);
        chk("add_exe_aluop", {29'b0, ALUOp}, 32'd0);
        chk("add_exe_alusrcb", {31'b0, ALUSrcB}, 32'd0);
        tick();
        chk("add_wb_state", {29'b0, state}, 32'd7);
        chk("add_wb_regwre", {31'b0, RegWre}, 32'd1);
        chk("add_wb_regdst", {30'b0, RegDst}, 32'd2);
        chk("add_wb_pcwre", {31'b0, PCWre}, 32'd1);
        chk("add_wb_wrregdsrc", {31'b0, WrRegDSrc}, 32'd1);
        chk("add_wb_dbdatasrc", {31'b0, DBDataSrc}, 32'd0);
        tick();
        chk("add_done_state", {29'b0, state}, 32'd0);

        // sub to EXE_AL, then reset mid-instruction
        funct = 6'b100010;
        tick(); tick();
        chk("sub_exe_state", {29'b0, state}, 32'd6);
        chk("sub_exe_aluop", {29'b0, ALUOp}, 32'd1);
        #2; RST = 1'b0; #1;
        chk("midrst_state", {29'b0, state}, 32'd0);
        chk("midrst_pcwre", {31'b0, PCWre}, 32'd0);
        chk("midrst_regwre", {31'b0, RegWre}, 32'd0);
        chk("midrst_mwr", {31'b0, mWR}, 32'd0);
        tick();
        chk("midrst_hold_state", {29'b0, state}, 32'd0);
        chk("midrst_hold_irwre", {31'b0, IRWre}, 32'd0);
        @(negedge CLK); RST = 1'b1; #1;
        chk("rel_irwre", {31'b0, IRWre}, 32'd1);
        chk("rel_state", {29'b0, state}, 32'd0);

        // lw: 000,001,010,011,100
        opcode = 6'b100011; funct = 6'b0;
        tick();
        chk("lw_id_state", {29'b0, state}, 32'd1);
        tick();
        chk("lw_exe_state", {29'b0, state}, 32'd2);
        chk("lw_exe_alusrcb", {31'b0, ALUSrcB}, 32'd1);
        chk("lw_exe_extsel", {31'b0, ExtSel}, 32'd1);
        tick();
        chk("lw_mem_state", {29'b0, state}, 32'd3);
        chk("lw_mem_mrd", {31'b0, mRD}, 32'd1);
        chk("lw_mem_mwr", {31'b0, mWR}, 32'd0);
        chk("lw_mem_pcwre", {31'b0, PCWre}, 32'd0);
        tick();
        chk("lw_wb_state", {29'b0, state}, 32'd4);
        chk("lw_wb_regwre", {31'b0, RegWre}, 32'd1);
        chk("lw_wb_regdst", {30'b0, RegDst}, 32'd1);
        chk("lw_wb_dbdatasrc", {31'b0, DBDataSrc}, 32'd1);
        chk("lw_wb_pcwre", {31'b0, PCWre}, 32'd1);
        tick();
        chk("lw_done_state", {29'b0, state}, 32'd0);

        // sw: 000,001,010,011
        opcode = 6'b101011;
        tick(); tick(); tick();
        chk("sw_mem_state", {29'b0, state}, 32'd3);
        chk("sw_mem_mwr", {31'b0, mWR}, 32'd1);
        chk("sw_mem_mrd", {31'b0, mRD}, 32'd0);
        chk("sw_mem_pcwre", {31'b0, PCWre}, 32'd1);
        chk("sw_mem_regwre", {31'b0, RegWre}, 32'd0);
        tick();
        chk("sw_done_state", {29'b0, state}, 32'd0);

        // beq taken / not taken
        opcode = 6'b000100; zero = 1'b1;
        tick(); tick();
        chk("beq1_state", {29'b0, state}, 32'd5);
        chk("beq1_pcsrc", {30'b0, PCSrc}, 32'd1);
        chk("beq1_aluop", {29'b0, ALUOp}, 32'd1);
        chk("beq1_pcwre", {31'b0, PCWre}, 32'd1);
        tick();
        chk("beq1_done_state", {29'b0, state}, 32'd0);
        zero = 1'b0;
        tick(); tick();
        chk("beq0_state", {29'b0, state}, 32'd5);
        chk("beq0_pcsrc", {30'b0, PCSrc}, 32'd0);
        chk("beq0_pcwre", {31'b0, PCWre}, 32'd1);
        tick();

        // ori through EXE_AL with zero-extension and OR
        opcode = 6'b001101;
        tick(); tick();
        chk("ori_exe_state", {29'b0, state}, 32'd6);
        chk("ori_extsel", {31'b0, ExtSel}, 32'd0);
        chk("ori_aluop", {29'b0, ALUOp}, 32'd3);
        tick();
        chk("ori_wb_regdst", {30'b0, RegDst}, 32'd1);
        chk("ori_wb_regwre", {31'b0, RegWre}, 32'd1);
        tick();

        // jal: 2 states
        opcode = 6'b000011;
        tick();
        chk("jal_id_state", {29'b0, state}, 32'd1);
        chk("jal_id_regwre", {31'b0, RegWre}, 32'd1);
        chk("jal_id_regdst", {30'b0, RegDst}, 32'd0);
        chk("jal_id_wrregdsrc", {31'b0, WrRegDSrc}, 32'd0);
        chk("jal_id_pcsrc", {30'b0, PCSrc}, 32'd3);
        chk("jal_id_pcwre", {31'b0, PCWre}, 32'd1);
        tick();
        chk("jal_done_state", {29'b0, state}, 32'd0);

        // jr
        opcode = 6'b000000; funct = 6'b001000;
        tick();
        chk("jr_id_pcsrc", {30'b0, PCSrc}, 32'd2);
        chk("jr_id_regwre", {31'b0, RegWre}, 32'd0);
        chk("jr_id_pcwre", {31'b0, PCWre}, 32'd1);
        tick();
        chk("jr_done_state", {29'b0, state}, 32'd0);

        // unknown opcode: NOP retiring in ID
        opcode = 6'b010101; funct = 6'b0;
        tick();
        chk("nop_id_pcwre", {31'b0, PCWre}, 32'd1);
        chk("nop_id_regwre", {31'b0, RegWre}, 32'd0);
        tick();
        chk("nop_done_state", {29'b0, state}, 32'd0);

        // halt
        opcode = 6'b111111;
        tick();
        chk("halt_id_state", {29'b0, state}, 32'd1);
        chk("halt_id_halted", {31'b0, halted}, 32'd0);
        tick();
        chk("halt_halted", {31'b0, halted}, 32'd1);
        opcode = 6'b000000; funct = 6'b100000;
        for (int i = 0; i < 10; i++) begin
            chk("halt_hold_state", {29'b0, state}, 32'd0);
            chk("halt_hold_en", {28'b0, IRWre, PCWre, RegWre, mWR}, 32'd0);
            tick();
        end
        chk("halt_still_halted", {31'b0, halted}, 32'd1);
        RST = 1'b0; #1;
        chk("halt_rst_clear", {31'b0, halted}, 32'd0);
        @(negedge CLK); RST = 1'b1; #1;
        chk("halt_rel_irwre", {31'b0, IRWre}, 32'd1);
        tick();
        chk("halt_rel_state", {29'b0, state}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
